rotary_value_ctl: RTL and testbench
===================================

# rotary_value_ctl

Controller between the rotary encoder decoder and the two-digit seven-segment display driver. It turns single-cycle clockwise/counter-clockwise event pulses and a select pulse into an 8-bit committed value. It supports two modes: direct wrap-around adjustment, and a per-nibble edit mode with a blinking active digit, commit and inactivity timeout. `disp` and `blank` feed the eight-bit-to-seven-segment converter; `value` is the committed result for the rest of the system.

## Interface
- `TIMEOUT_CYCLES`, default 50_000_000: inactivity limit in edit states (1 s at 50 MHz); minimum 2.
- `BLINK_CYCLES`, default 12_500_000: half-period of active-digit blink; minimum 2.
- `clk`  in  1  system clock; one clock domain.
- `reset_n`  in  1  reset, synchronous, active-low.
- `rotary_cw`  in  1  single-cycle pulse, one clockwise detent.
- `rotary_ccw`  in  1  single-cycle pulse, one counter-clockwise detent.
- `sel`  in  1  single-cycle pulse, debounced push-button press.
- `value`  out  8  committed value.
- `disp`  out  8  value to display: `value` in IDLE, edit copy in edit states.
- `blank`  out  2  digit blank mask: [1] = high nibble, [0] = low nibble; 1 = segments off.
- `editing`  out  1  high in EDIT_HI or EDIT_LO.
- `commit`  out  1  one-cycle pulse when an edit is written to `value`.

## Operation
- States: IDLE, EDIT_HI, EDIT_LO. All outputs are registered.
- Accepted rotary event: exactly one of `rotary_cw`/`rotary_ccw` high. Both high in the same cycle is ignored: no change and no timer restart.
- **IDLE behaviour**
  - cw: `value` <= `value`+1 mod 256 (0xFF -> 0x00).
  - ccw: `value` <= `value`-1 mod 256 (0x00 -> 0xFF).
  - `sel`: edit <= `value`, go to EDIT_HI.
- **EDIT_HI behaviour**
  - cw/ccw: edit[7:4] +/-1 mod 16. There is no carry into or out of the nibble; edit[3:0] is unchanged.
  - `sel`: go to EDIT_LO.
- **EDIT_LO behaviour**
  - cw/ccw: edit[3:0] +/-1 mod 16. There is no borrow or carry into edit[7:4].
  - `sel`: `value` <= edit, `commit` = 1 for one cycle, go to IDLE.
- **Timeout:** in either edit state, if no accepted rotary event and no `sel` occur for `TIMEOUT_CYCLES`, go to IDLE and discard edit. `value` is unchanged and there is no `commit`.
- **Priority:** `sel` in the same cycle as a rotary pulse wins. The rotary pulse is dropped and not applied in either the old or new state.
- **Blank**
  - IDLE: `blank` = 00.
  - EDIT_HI: `blank`[0] = 0 and `blank`[1] toggles every `BLINK_CYCLES`.
  - EDIT_LO: `blank`[1] = 0 and `blank`[0] toggles every `BLINK_CYCLES`.
  - The blink counter restarts with the active digit visible (blank bit 0) on state entry and on every accepted rotary event.
- **Reset:**
  - `reset_n` low at a rising edge forces IDLE.
  - `value` = 0x00, edit = 0x00, `disp` = 0x00, `blank` = 00, `editing` = 0, `commit` = 0.
  - Timeout and blink counters are cleared.
  - Reset mid-edit discards the edit with no `commit`.

## Timing
- All inputs are sampled at the rising edge of `clk`. The effect is visible on outputs immediately after that same edge (1-cycle latency).
- `commit` and the new `value` appear in the same cycle. `editing` falls in that same cycle.
- `disp` tracks the internal `value`/edit/state in the same cycle; there is no extra pipeline stage.
- **Timeout counter**
  - Cleared on edit-state entry and on each accepted event or `sel`; otherwise increments each cycle.
  - When it equals `TIMEOUT_CYCLES`-1 and no event is present, the next edge enters IDLE.
  - So `editing` falls exactly `TIMEOUT_CYCLES` edges after the edge that registered the last activity.
- **Blink counter**
  - Counts 0..`BLINK_CYCLES`-1 and wraps.
  - On wrap it toggles the active blank bit.
  - The first toggle (digit off) is `BLINK_CYCLES` edges after state entry or the last accepted rotary event.
- Back-to-back pulses on consecutive cycles are each applied; no event is lost except by the simultaneous-event rules above.
- Counter widths: `$clog2` of the respective parameter. The counters do not overflow past the parameter value.

## Test plan
All directed tests use `TIMEOUT_CYCLES`=20 and `BLINK_CYCLES`=4.
- **Reset and IDLE wrap:** reset, then 3 ccw pulses.
  - Required: `value` 0xFF, 0xFE, 0xFD on successive updates.
  - Then 3 cw pulses return `value` to 0x00; `blank`=00 and `editing`=0 throughout.
- **Full edit and commit:** `value`=0x3A; `sel`, 6 ccw, `sel`, 7 cw, `sel`.
  - Required: high nibble 3 -> D (no borrow into the low nibble), low nibble A -> 1, so edit 0xD1.
  - `commit` is high for exactly one cycle with `value`=0xD1, and `editing` falls in the same cycle.
- **Timeout discard:** `value`=0x55; `sel`, 2 cw (`disp`=0x75), then idle.
  - Required: `editing` falls exactly 20 edges after the last cw.
  - After that, `disp`=`value`=0x55 and `commit` never pulses.
- **Simultaneous events:** in EDIT_HI, assert `rotary_cw`+`rotary_ccw` together.
  - Required: no change, and the timeout still expires 20 edges after the earlier activity.
  - `sel`+`rotary_cw` together: go to EDIT_LO with edit unchanged.
- **Blink:** enter EDIT_HI and hold idle.
  - Required: `blank`[1] pattern 0,0,0,0,1,1,1,1,0... with `blank`[0]=0.
  - A cw pulse mid-blank forces `blank`[1]=0 on the next cycle and restarts the 4-cycle phase.
- **Reset mid-edit:** in EDIT_LO with edit 0x9C and `value` 0x12, drive `reset_n` low for 1 cycle.
  - Required: all outputs are at reset values on the next cycle, and `commit` stays 0.

Source files
------------

// File: rtl/rotary_value_ctl.sv
// rotary_value_ctl: turns rotary encoder cw/ccw pulses and a select pulse into
// an 8-bit committed value. IDLE adjusts the value directly with wrap-around.
// The two edit states adjust one nibble at a time on a working copy, blink the
// active digit, and return to IDLE on commit or after an inactivity timeout.
module rotary_value_ctl #(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int BLINK_CYCLES   = 12_500_000
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_rotary_cw,
    input  logic       i_rotary_ccw,
    input  logic       i_sel,
    output logic [7:0] o_value,
    output logic [7:0] o_disp,
    output logic [1:0] o_blank,
    output logic       o_editing,
    output logic       o_commit
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EDIT_HI = 2'd1,
        S_EDIT_LO = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_value, w_value_nxt;
    logic [7:0]    r_edit, w_edit_nxt;
    logic [TW-1:0] r_tmo, w_tmo_nxt;
    logic [BW-1:0] r_blink, w_blink_nxt;
    logic          r_blank_bit, w_blank_bit_nxt;
    logic          w_commit_nxt;
    logic [7:0]    w_disp_nxt;
    logic [1:0]    w_blank_nxt;

    // Exactly one direction pulse counts as an event; both together are ignored.
    logic w_cw, w_ccw, w_rot;
    assign w_cw  = i_rotary_cw & ~i_rotary_ccw;
    assign w_ccw = i_rotary_ccw & ~i_rotary_cw;
    assign w_rot = w_cw | w_ccw;

    function automatic logic [7:0] byte_step(input logic [7:0] b, input logic up);
        return up ? b + 8'd1 : b - 8'd1;
    endfunction

    function automatic logic [3:0] nib_step(input logic [3:0] n, input logic up);
        return up ? n + 4'd1 : n - 4'd1;
    endfunction

    // Next-state, datapath and output decode; sel outranks any rotary pulse.
    always_comb begin
        w_state_nxt     = r_state;
        w_value_nxt     = r_value;
        w_edit_nxt      = r_edit;
        w_tmo_nxt       = r_tmo;
        w_blink_nxt     = r_blink;
        w_blank_bit_nxt = r_blank_bit;
        w_commit_nxt    = 1'b0;

        case (r_state)
            S_EDIT_HI, S_EDIT_LO: begin
                if (i_sel) begin
                    w_tmo_nxt       = '0;
                    w_blink_nxt     = '0;
                    w_blank_bit_nxt = 1'b0;
                    if (r_state == S_EDIT_HI) begin
                        w_state_nxt = S_EDIT_LO;
                    end else begin
                        w_value_nxt  = r_edit;
                        w_commit_nxt = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end
                end else if (w_rot) begin
                    w_tmo_nxt       = '0;
                    w_blink_nxt     = '0;
                    w_blank_bit_nxt = 1'b0;
                    if (r_state == S_EDIT_HI)
                        w_edit_nxt = {nib_step(r_edit[7:4], w_cw), r_edit[3:0]};
                    else
                        w_edit_nxt = {r_edit[7:4], nib_step(r_edit[3:0], w_cw)};
                end else if (r_tmo == T_LAST) begin
                    // Inactivity: drop the working copy, value stays as it was.
                    w_state_nxt     = S_IDLE;
                    w_tmo_nxt       = '0;
                    w_blink_nxt     = '0;
                    w_blank_bit_nxt = 1'b0;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                    if (r_blink == B_LAST) begin
                        w_blink_nxt     = '0;
                        w_blank_bit_nxt = ~r_blank_bit;
                    end else begin
                        w_blink_nxt = r_blink + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_tmo_nxt       = '0;
                w_blink_nxt     = '0;
                w_blank_bit_nxt = 1'b0;
                if (i_sel) begin
                    w_edit_nxt  = r_value;
                    w_state_nxt = S_EDIT_HI;
                end else if (w_rot) begin
                    w_value_nxt = byte_step(r_value, w_cw);
                end
            end
        endcase

        w_disp_nxt  = (w_state_nxt == S_IDLE) ? w_value_nxt : w_edit_nxt;
        w_blank_nxt = 2'b00;
        if (w_state_nxt == S_EDIT_HI) w_blank_nxt = {w_blank_bit_nxt, 1'b0};
        if (w_state_nxt == S_EDIT_LO) w_blank_nxt = {1'b0, w_blank_bit_nxt};
    end

    // State, counters and registered outputs; reset returns everything to IDLE zeros.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_value     <= 8'h00;
            r_edit      <= 8'h00;
            r_tmo       <= '0;
            r_blink     <= '0;
            r_blank_bit <= 1'b0;
            o_disp      <= 8'h00;
            o_blank     <= 2'b00;
            o_editing   <= 1'b0;
            o_commit    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_value     <= w_value_nxt;
            r_edit      <= w_edit_nxt;
            r_tmo       <= w_tmo_nxt;
            r_blink     <= w_blink_nxt;
            r_blank_bit <= w_blank_bit_nxt;
            o_disp      <= w_disp_nxt;
            o_blank     <= w_blank_nxt;
            o_editing   <= (w_state_nxt != S_IDLE);
            o_commit    <= w_commit_nxt;
        end
    end

    assign o_value = r_value;

endmodule

// File: tb/tb_rotary_value_ctl.sv
// Bench for rotary_value_ctl: directed scenarios followed by random pulses,
// expected outputs come from an age-based behavioural model and are queued
// for a monitor that compares one entry per clock.
module tb_rotary_value_ctl;

    localparam int T = 20;
    localparam int B = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rotary_cw = 1'b0;
    logic       rotary_ccw = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] value, disp;
    logic [1:0] blank;
    logic       editing, commit;

    rotary_value_ctl #(.TIMEOUT_CYCLES(T), .BLINK_CYCLES(B)) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_rotary_cw (rotary_cw),
        .i_rotary_ccw(rotary_ccw),
        .i_sel       (sel),
        .o_value     (value),
        .o_disp      (disp),
        .o_blank     (blank),
        .o_editing   (editing),
        .o_commit    (commit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] value;
        logic [7:0] disp;
        logic [1:0] blank;
        logic       editing;
        logic       commit;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Behavioural model: mode 0 idle, 1 high-nibble edit, 2 low-nibble edit.
    // Ages count edges since the last activity / last blink restart.
    int         m_mode = 0;
    logic [7:0] m_value = 8'h00;
    logic [7:0] m_edit = 8'h00;
    int         m_act_age = 0;
    int         m_blink_age = 0;
    logic       m_commit = 1'b0;

    task automatic cmp(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_edge(input logic rn, input logic cw, input logic ccw, input logic s);
        int hi, lo;
        logic rot;
        m_commit = 1'b0;
        if (!rn) begin
            m_mode = 0; m_value = 8'h00; m_edit = 8'h00; m_act_age = 0; m_blink_age = 0;
            return;
        end
        rot = (cw != ccw);
        if (m_mode == 0) begin
            if (s) begin
                m_edit = m_value; m_mode = 1; m_act_age = 0; m_blink_age = 0;
            end else if (rot) begin
                m_value = cw ? m_value + 8'd1 : m_value - 8'd1;
            end
        end else begin
            if (s) begin
                if (m_mode == 1) m_mode = 2;
                else begin m_value = m_edit; m_commit = 1'b1; m_mode = 0; end
                m_act_age = 0; m_blink_age = 0;
            end else if (rot) begin
                hi = m_edit / 16;
                lo = m_edit % 16;
                if (m_mode == 1) hi = (hi + (cw ? 1 : 15)) % 16;
                else             lo = (lo + (cw ? 1 : 15)) % 16;
                m_edit = 8'(hi * 16 + lo);
                m_act_age = 0; m_blink_age = 0;
            end else begin
                m_act_age++;
                m_blink_age++;
                if (m_act_age == T) m_mode = 0;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        logic phase;
        phase     = ((m_blink_age / B) % 2) == 1;
        e.value   = m_value;
        e.disp    = (m_mode == 0) ? m_value : m_edit;
        e.blank   = (m_mode == 1) ? {phase, 1'b0} : (m_mode == 2) ? {1'b0, phase} : 2'b00;
        e.editing = (m_mode != 0);
        e.commit  = m_commit;
        return e;
    endfunction

    // Drive one clock's worth of inputs and queue the response it must produce.
    task automatic step(input logic rn, input logic cw, input logic ccw, input logic s);
        @(negedge clk);
        reset_n = rn; rotary_cw = cw; rotary_ccw = ccw; sel = s;
        model_edge(rn, cw, ccw, s);
        q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cws(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic ccws(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    // Monitor: one queued response per rising edge, sampled just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("value",   int'(value),   int'(e.value));
                cmp("disp",    int'(disp),    int'(e.disp));
                cmp("blank",   int'(blank),   int'(e.blank));
                cmp("editing", int'(editing), int'(e.editing));
                cmp("commit",  int'(commit),  int'(e.commit));
            end
        end
    end

    initial begin
        // Reset and IDLE wrap
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        cmp("reset_value", int'(value), 0);
        cmp("reset_blank", int'(blank), 0);
        ccws(1); settle(); cmp("wrap_ccw_ff", int'(value), 8'hFF);
        ccws(2); settle(); cmp("wrap_ccw_fd", int'(value), 8'hFD);
        cws(3);  settle(); cmp("wrap_cw_00", int'(value), 8'h00);

        // Full edit and commit from 0x3A
        cws(8'h3A);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        ccws(6); settle(); cmp("hi_nibble_d", int'(disp), 8'hDA);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        cws(7); settle(); cmp("lo_nibble_1", int'(disp), 8'hD1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        settle();
        cmp("commit_pulse", int'(commit), 1);
        cmp("commit_value", int'(value), 8'hD1);
        cmp("commit_editing", int'(editing), 0);
        idle(1); settle(); cmp("commit_one_cycle", int'(commit), 0);

        // Timeout discard from 0x55
        ccws(8'hD1 - 8'h55);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        cws(2); settle(); cmp("timeout_disp_75", int'(disp), 8'h75);
        idle(T - 1); settle(); cmp("timeout_still_editing", int'(editing), 1);
        idle(1); settle();
        cmp("timeout_editing_low", int'(editing), 0);
        cmp("timeout_disp", int'(disp), 8'h55);
        cmp("timeout_value", int'(value), 8'h55);

        // Simultaneous events
        step(1'b1, 1'b0, 1'b0, 1'b1);
        cws(1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        settle(); cmp("both_no_change", int'(disp), 8'h65);
        idle(T - 2); settle(); cmp("both_before_timeout", int'(editing), 1);
        idle(1); settle(); cmp("both_timeout", int'(editing), 0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        settle();
        cmp("sel_cw_disp", int'(disp), 8'h55);
        cmp("sel_cw_lo", int'(blank), 0);
        step(1'b1, 1'b0, 1'b0, 1'b1);

        // Blink with a restart mid-blank
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(5); settle(); cmp("blink_off", int'(blank), 2'b10);
        cws(1); settle(); cmp("blink_restart", int'(blank), 2'b00);
        idle(9);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(6);
        step(1'b1, 1'b0, 1'b0, 1'b1);

        // Reset mid-edit: value 0x12, edit 0x9C in the low-nibble state
        step(1'b0, 1'b0, 1'b0, 1'b0);
        cws(8'h12);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        cws(8);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        cws(10); settle(); cmp("pre_reset_disp", int'(disp), 8'h9C);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        cmp("midreset_value", int'(value), 0);
        cmp("midreset_disp", int'(disp), 0);
        cmp("midreset_editing", int'(editing), 0);
        cmp("midreset_commit", int'(commit), 0);

        // Random phase, with occasional long quiet stretches to reach timeouts
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 299) == 0) step(1'b0, 1'b0, 1'b0, 1'b0);
            else if ($urandom_range(0, 59) == 0) idle(int'($urandom_range(T - 2, T + 3)));
            else if (r < 28) step(1'b1, 1'b1, 1'b0, $urandom_range(0, 9) == 0);
            else if (r < 56) step(1'b1, 1'b0, 1'b1, $urandom_range(0, 9) == 0);
            else if (r < 60) step(1'b1, 1'b1, 1'b1, 1'b0);
            else if (r < 68) step(1'b1, 1'b0, 1'b0, 1'b1);
            else step(1'b1, 1'b0, 1'b0, 1'b0);
        end

        idle(1);
        @(negedge clk);
        @(negedge clk);
        cmp("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
